// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the SRAM slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte-lane enables for a legal transfer of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: return 4'b0001 << off;
      HSIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  // Oversize or misaligned access: answered with ERROR, never writes.
  function automatic logic size_err(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: return 1'b0;
      HSIZE_HALF: return off[0];
      HSIZE_WORD: return off != 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sram_bytewrite.sv
// Word-wide RAM with per-byte write enables; synchronous write, asynchronous read.
module sram_bytewrite #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  // Commit only the enabled byte lanes; other lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite data-RAM slave with configurable wait states and two-cycle ERROR
// responses for misaligned or oversize accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  // The counter is loaded with one less than the wait count because the
  // cycle that sees it at zero is itself the last wait cycle.
  localparam logic [3:0] LP_WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [2:0]        r_size;
  logic              r_write;
  logic              r_err;
  logic              r_hready;
  logic              r_hresp;
  logic [31:0]       r_hrdata;

  logic              w_accept;
  logic              w_err;
  logic              w_rd_cycle;
  logic [3:0]        w_we;
  logic [31:0]       w_rd_word;
  logic              w_unused;

  assign w_accept   = r_hready & HSEL & HTRANS[1];
  assign w_err      = size_err(HSIZE, HADDR[1:0]);
  assign w_rd_cycle = (r_state == ST_DATA) && !r_write;
  assign w_we       = ((r_state == ST_DATA) && r_write && !r_err) ? lane_mask(r_size, r_off) : 4'b0000;
  // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ.
  assign w_unused   = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

  sram_bytewrite #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_addr),
    .wdata (HWDATA),
    .raddr (r_addr),
    .rdata (w_rd_word)
  );

  // Slave FSM: captures the address phase and drives registered HREADY/HRESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_off    <= 2'b00;
      r_size   <= 3'b000;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
    end else begin
      if (w_accept) begin
        r_addr  <= HADDR[ADDR_W+1:2];
        r_off   <= HADDR[1:0];
        r_size  <= HSIZE;
        r_write <= HWRITE;
        r_err   <= w_err;
      end
      case (r_state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (w_accept && w_err) begin
            r_state  <= ST_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_ERROR;
          end else if (w_accept && (WAIT_STATES > 0)) begin
            r_state  <= ST_WAIT;
            r_cnt    <= LP_WS_LOAD;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_OKAY;
          end else if (w_accept) begin
            r_state  <= ST_DATA;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
          end else begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= ST_DATA;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Keep the last read word so HRDATA holds outside read data phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hrdata <= 32'h0;
    end else if (w_rd_cycle) begin
      r_hrdata <= w_rd_word;
    end
  end

  // The read data phase shows the array directly so a write committed on the
  // previous edge is visible without forwarding.
  assign HRDATA = w_rd_cycle ? w_rd_word : r_hrdata;
  assign HREADY = r_hready;
  assign HRESP  = r_hresp;

endmodule
